// File: rtl/bcd2bin_converter_pkg.sv
// bcd_pkg: shared FSM encodings and BCD constants for the BCD-to-binary converter
package bcd_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_t;
    localparam int BCD_W       = 4;
    localparam int BCD_MAX     = 9;
    localparam int CORR_THRESH = 8;
    localparam int CORR_SUB    = 3;
endpackage

// File: rtl/bcd2bin_converter_if.sv
// bcd2bin_converter_if: start/done handshake plus operand/result bus
//   start   : request a conversion (master -> slave)
//   bcd_in  : packed BCD operand, digit 0 in bits [3:0] (master -> slave)
//   busy    : conversion in progress (slave -> master)
//   done    : one-cycle result-valid pulse (slave -> master)
//   bin_out : binary result, held until the next done (slave -> master)
//   err     : invalid-digit flag, held until the next done (slave -> master)
interface bcd2bin_converter_if #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
);
    logic                  start;
    logic [4*DIGITS-1:0]   bcd_in;
    logic                  busy;
    logic                  done;
    logic [BIN_W-1:0]      bin_out;
    logic                  err;
    modport master (output start, bcd_in, input busy, done, bin_out, err);
    modport slave  (input start, bcd_in, output busy, done, bin_out, err);
endinterface

// File: rtl/bcd2bin_converter_digit_corr.sv
// bcd_digit_corr: reverse double-dabble digit correction (subtract 3 when >= 8)
//   i_digit : post-shift BCD digit field
//   o_digit : corrected digit field
module bcd_digit_corr
    import bcd_pkg::*;
(
    input  logic [BCD_W-1:0] i_digit,
    output logic [BCD_W-1:0] o_digit
);
    assign o_digit = (i_digit >= BCD_W'(CORR_THRESH)) ? i_digit - BCD_W'(CORR_SUB) : i_digit;
endmodule

// File: rtl/bcd2bin_converter.sv
// bcd2bin_converter: sequential packed-BCD to binary converter (reverse double-dabble)
//   clk   : system clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : slave side of bcd2bin_converter_if (start, bcd_in, busy, done, bin_out, err)
// Optional feature: define BCD_CHECK_EN to flag operands containing a digit > 9
// (err=1, bin_out=0 at done); otherwise err is tied low.
module bcd2bin_converter
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic                  clk,
    input  logic                  reset,
    bcd2bin_converter_if.slave    bus
);
    localparam int SR_W  = BCD_W*DIGITS + BIN_W;
    localparam int CNT_W = $clog2(BIN_W+1);

    state_t            r_state;
    logic [SR_W-1:0]   r_sr;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic              r_bad;
    logic [BIN_W-1:0]  r_bin;
    logic [SR_W-1:0]   w_shift;
    logic [SR_W-1:0]   w_next;
    logic              w_bad;

    assign w_shift              = r_sr >> 1;
    assign w_next[BIN_W-1:0]    = w_shift[BIN_W-1:0];

    // Correction acts on the BCD digit fields after the shift, every iteration.
    for (genvar d = 0; d < DIGITS; d++) begin : g_corr
        bcd_digit_corr u_corr (
            .i_digit (w_shift[BIN_W+BCD_W*d +: BCD_W]),
            .o_digit (w_next[BIN_W+BCD_W*d +: BCD_W])
        );
    end

`ifdef BCD_CHECK_EN
    logic [DIGITS-1:0] w_dbad;
    for (genvar d = 0; d < DIGITS; d++) begin : g_chk
        assign w_dbad[d] = bus.bcd_in[BCD_W*d +: BCD_W] > BCD_W'(BCD_MAX);
    end
    assign w_bad = |w_dbad;
`else
    assign w_bad = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_sr    <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_bad   <= 1'b0;
            r_bin   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: if (bus.start) begin
                    r_sr    <= {bus.bcd_in, {BIN_W{1'b0}}};
                    r_cnt   <= '0;
                    r_bad   <= w_bad;
                    r_busy  <= 1'b1;
                    r_state <= ST_CONV;
                end
                ST_CONV: begin
                    r_sr  <= w_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                    // Results are registered on the last iteration so they
                    // appear together with done in the DONE cycle.
                    if (r_cnt == CNT_W'(BIN_W-1)) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                        r_err   <= r_bad;
                        r_bin   <= r_bad ? '0 : w_next[BIN_W-1:0];
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.bin_out = r_bin;
    assign bus.err     = r_err;
endmodule

// File: tb/tb_bcd2bin_converter.sv
// tb_bcd2bin_converter: directed and randomized checks of bcd2bin_converter against a decimal-value model
module tb_bcd2bin_converter;
    localparam int BW = 14;
`ifdef BCD_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    bcd2bin_converter_if #(.DIGITS(4), .BIN_W(BW)) bus();
    bcd2bin_converter #(.DIGITS(4), .BIN_W(BW)) dut (.clk(clk), .reset(reset), .bus(bus));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int dec(input logic [15:0] b);
        int v = 0;
        for (int i = 3; i >= 0; i--) v = v*10 + int'(b[4*i +: 4]);
        return v;
    endfunction

    function automatic bit has_bad(input logic [15:0] b);
        bit r = 0;
        for (int i = 0; i < 4; i++) if (b[4*i +: 4] > 4'd9) r = 1;
        return r;
    endfunction

    function automatic logic [15:0] rnd_bcd();
        logic [15:0] b;
        for (int i = 0; i < 4; i++)
            b[4*i +: 4] = (CHK_EN && $urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
        return b;
    endfunction

    // Model: accepted request -> 15 busy cycles, done in the last; result = decimal value.
    int m_left = 0;
    int m_val = 0;
    bit m_err = 0;
    int m_last = 0;
    bit m_last_err = 0;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_left = 0;
            m_last = 0;
            m_last_err = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 1) begin
                m_last = m_val;
                m_last_err = m_err;
            end
        end else if (bus.start === 1'b1) begin
            m_left = BW + 1;
            m_err = CHK_EN && has_bad(bus.bcd_in);
            m_val = m_err ? 0 : dec(bus.bcd_in);
        end
    end

    always @(negedge clk) begin
        chk("busy", 32'(bus.busy), 32'(m_left > 0));
        chk("done", 32'(bus.done), 32'(m_left == 1));
        chk("bin_out", 32'(bus.bin_out), 32'(m_last));
        chk("err", 32'(bus.err), 32'(m_last_err));
    end

    task automatic conv(input logic [15:0] b, input int lit, input bit lerr, input string nm);
        int n = 1;
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.bcd_in = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.bcd_in = 16'($urandom);
        @(negedge clk);
        while (bus.done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_lat"}, 32'(n), 32'd15);
        chk({nm, "_val"}, 32'(bus.bin_out), 32'(lit));
        chk({nm, "_err"}, 32'(bus.err), 32'(lerr));
    endtask

    initial begin
        int nd;
        int last;
        bus.start = 1'b0;
        bus.bcd_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_bin", 32'(bus.bin_out), 0);
        chk("rst_err", 32'(bus.err), 0);
        reset = 1'b1;

        conv(16'h0000, 0, 0, "t1");
        conv(16'h1234, 14'h04D2, 0, "t2");
        conv(16'h9999, 14'h270F, 0, "t3a");
        conv(16'h0001, 14'h0001, 0, "t3b");

        // start held high: a new conversion every 16 cycles
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.bcd_in = 16'h0042;
        nd = 0;
        last = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                if (nd > 0) chk("t4_period", 32'(c - last), 32'd16);
                chk("t4_val", 32'(bus.bin_out), 32'd42);
                last = c;
                nd++;
            end
            if (c == 39) bus.start = 1'b0;
        end
        chk("t4_count", 32'(nd), 32'd3);

`ifdef BCD_CHECK_EN
        conv(16'h00A5, 0, 1, "t5a");
        conv(16'h0005, 5, 0, "t5b");
`endif

        // reset in the middle of a conversion
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.bcd_in = 16'h0777;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("t6_busy", 32'(bus.busy), 0);
        chk("t6_bin", 32'(bus.bin_out), 0);
        nd = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.done === 1'b1) nd++;
        end
        chk("t6_nodone", 32'(nd), 0);
        @(posedge clk); #1;
        reset = 1'b1;
        conv(16'h0100, 100, 0, "t6");

        // randomized traffic: gaps, held start, bcd_in churn while busy
        for (int it = 0; it < 30; it++) begin
            @(posedge clk); #1;
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            bus.start = 1'b1;
            bus.bcd_in = rnd_bcd();
            repeat ($urandom_range(1, 20)) begin
                @(posedge clk); #1;
                bus.bcd_in = rnd_bcd();
            end
            bus.start = 1'b0;
            for (int k = 0; k < 40 && m_left > 0; k++) @(posedge clk);
            if (m_left > 0) chk("rnd_timeout", 32'(m_left), 0);
        end

        repeat (3) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
